// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the vector CPU.
// Owns the PC, drives a synchronous instruction memory and squashes the
// wrong-path word as VNOP on a taken redirect. A redirect that arrives while
// the stage is stalled is held off until the stall clears.
// Optional build macro: IF_FETCH_PERF_EN adds fetch/squash performance counters.
module if_fetch_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4,
    parameter logic [31:0] NOP_INST  = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        halt,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [0:31] branch_target,
    output logic        imem_en,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_rdata,
    output logic [0:31] IF_inst,
    output logic [0:31] IF_pc,
    output logic        IF_valid
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [0:31] perf_fetch_cnt,
    output logic [0:31] perf_squash_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      r_state;
    logic [0:31] r_pc;
    logic [0:31] r_pc_q;
    logic        r_fv;
    logic        r_pend;
    logic [0:31] r_pend_pc;

    state_t      w_state_nxt;
    logic [0:31] w_pc_nxt;
    logic [0:31] w_pc_q_nxt;
    logic        w_fv_nxt;
    logic        w_pend_nxt;
    logic [0:31] w_pend_pc_nxt;
    logic        w_fetch;
    logic        w_squash;
    logic [0:31] w_tgt;
    logic [0:31] w_pc_inc;

    // Word-align the redirect target and precompute the sequential PC.
    always_comb begin
        w_tgt    = branch_target & 32'hFFFF_FFFC;
        w_pc_inc = r_pc + 32'(PC_STEP);
    end

    // Next-state, PC and pending-redirect logic; halt outranks every other request in RUN.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pc_q_nxt    = r_pc_q;
        w_fv_nxt      = r_fv;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_fetch       = 1'b0;
        w_squash      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = BOOT_ADDR;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HALT;
                    w_fv_nxt    = 1'b0;
                    w_pend_nxt  = 1'b0;
                end else if (stall) begin
                    // Memory is not enabled, so rdata and the output registers hold.
                    if (branch_taken) begin
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = w_tgt;
                    end
                end else if (branch_taken || r_pend) begin
                    // A fresh request is newer than a held-off one, so it wins.
                    w_pc_nxt   = branch_taken ? w_tgt : r_pend_pc;
                    w_fv_nxt   = 1'b0;
                    w_pend_nxt = 1'b0;
                    w_squash   = 1'b1;
                end else begin
                    w_fetch    = 1'b1;
                    w_pc_nxt   = w_pc_inc;
                    w_pc_q_nxt = r_pc;
                    w_fv_nxt   = 1'b1;
                end
            end
            ST_HALT: begin
                w_fv_nxt   = 1'b0;
                w_pend_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = BOOT_ADDR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_fv_nxt    = 1'b0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // State, PC and fetch-tracking registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= BOOT_ADDR;
            r_pc_q    <= '0;
            r_fv      <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pc_q    <= w_pc_q_nxt;
            r_fv      <= w_fv_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    // Outputs: memory holds rdata while not enabled, so a valid word stays stable.
    always_comb begin
        imem_en   = w_fetch;
        imem_addr = r_pc;
        IF_inst   = r_fv ? imem_rdata : NOP_INST;
        IF_pc     = r_pc_q;
        IF_valid  = r_fv;
    end

`ifdef IF_FETCH_PERF_EN
    logic [0:31] r_perf_fetch;
    logic [0:31] r_perf_squash;

    // Saturating counters; fetch and squash only occur in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetch  <= '0;
            r_perf_squash <= '0;
        end else begin
            if (w_fetch && (r_perf_fetch != '1)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_squash && (r_perf_squash != '1)) begin
                r_perf_squash <= r_perf_squash + 32'd1;
            end
        end
    end

    // Counter outputs.
    always_comb begin
        perf_fetch_cnt  = r_perf_fetch;
        perf_squash_cnt = r_perf_squash;
    end
`endif

endmodule
